mul_field_sequencer: RTL and testbench

Multi-cycle register-field decoder and register-file access sequencer for the multiply/data-processing datapath. It accepts one instruction per handshake and decodes its register fields for MUL, MLA, UMULL, UMLAL, SMULL, SMLAL and plain data-processing. It then issues operand reads over one or more cycles, waits for the execute stage, and sequences one or two writebacks. It sits between instruction decode and the register file / multiplier in the multi-cycle core.

---
 rtl/mul_field_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mul_field_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_field_sequencer.sv
// rtl/mul_field_sequencer.sv - register-field decode and register-file read/writeback sequencer for mul/data-processing
// Optional feature macro: LONG_MUL_EN (enables UMULL/UMLAL/SMULL/SMLAL long-multiply sequencing)
module mul_field_sequencer #(
  parameter int REG_AW   = 4,
  parameter int RD_PORTS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              op_mul,
  output logic              rd_en,
  output logic [REG_AW-1:0] ra1,
  output logic [REG_AW-1:0] ra2,
  output logic [1:0]        rd_tag,
  input  logic              exec_done,
  output logic              we,
  output logic [REG_AW-1:0] wa,
  output logic              wsel,
  output logic              long_mul,
  output logic              signed_mul,
  output logic              accumulate,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_WAIT = 3'd3,
    S_WB0  = 3'd4,
    S_WB1  = 3'd5
  } state_t;

  localparam bit ONE_PORT = (RD_PORTS == 1);

  state_t            state;
  logic              half;      // second operand cycle of a read state when only one port exists
  logic [REG_AW-1:0] f_rn;
  logic [REG_AW-1:0] f_rm;
  logic [REG_AW-1:0] f_ra;      // Ra for MLA, RdLo for long forms
  logic [REG_AW-1:0] f_rd;      // Rd for short forms, RdHi for long forms
  logic              long_q;
  logic              signed_q;
  logic              acc_q;
  logic              illegal_q;

  // Decoded view of the incoming instruction; only captured on accept
  logic [REG_AW-1:0] d_rn, d_rm, d_ra, d_rd;
  logic              d_long, d_signed, d_acc, d_illegal;
  logic              unused_bits;

  // Field extraction depends on whether the instruction is multiply class
  always_comb begin
    d_rn      = op_mul ? instr[3:0]   : instr[19:16];
    d_rm      = op_mul ? instr[11:8]  : instr[3:0];
    d_ra      = op_mul ? instr[15:12] : '0;
    d_rd      = op_mul ? instr[19:16] : instr[15:12];
    d_acc     = op_mul & instr[21];
`ifdef LONG_MUL_EN
    d_long    = op_mul & instr[23];
    d_signed  = op_mul & instr[22];
    d_illegal = 1'b0;
`else
    // Long forms degrade to MUL/MLA; flag the encoding so software can trap it
    d_long    = 1'b0;
    d_signed  = 1'b0;
    d_illegal = op_mul & instr[23];
`endif
  end

`ifdef LONG_MUL_EN
  assign unused_bits = ^{instr[31:24], instr[20], instr[7:4]};
`else
  assign unused_bits = ^{instr[31:24], instr[22], instr[20], instr[7:4]};
`endif

  // Sequencer state, latched fields and the illegal pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      half      <= 1'b0;
      f_rn      <= '0;
      f_rm      <= '0;
      f_ra      <= '0;
      f_rd      <= '0;
      long_q    <= 1'b0;
      signed_q  <= 1'b0;
      acc_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        S_IDLE: begin
          half <= 1'b0;
          if (in_valid) begin
            f_rn      <= d_rn;
            f_rm      <= d_rm;
            f_ra      <= d_ra;
            f_rd      <= d_rd;
            long_q    <= d_long;
            signed_q  <= d_signed;
            acc_q     <= d_acc;
            illegal_q <= d_illegal;
            state     <= S_RD0;
          end
        end
        S_RD0: begin
          if (ONE_PORT && !half) begin
            half <= 1'b1;
          end else begin
            half  <= 1'b0;
            state <= acc_q ? S_RD1 : S_WAIT;
          end
        end
        S_RD1: begin
          if (ONE_PORT && !half) begin
            half <= 1'b1;
          end else begin
            half  <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (exec_done) state <= S_WB0;
        end
        S_WB0, S_WB1: begin
          if (state == S_WB0 && long_q) begin
            state <= S_WB1;
          end else begin
            // Fields are only meaningful for the instruction in flight
            state    <= S_IDLE;
            f_rn     <= '0;
            f_rm     <= '0;
            f_ra     <= '0;
            f_rd     <= '0;
            long_q   <= 1'b0;
            signed_q <= 1'b0;
            acc_q    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state and latched fields
  always_comb begin
    in_ready = (state == S_IDLE);
    rd_en    = 1'b0;
    ra1      = '0;
    ra2      = '0;
    rd_tag   = 2'd0;
    we       = 1'b0;
    wa       = '0;
    wsel     = 1'b0;
    case (state)
      S_RD0: begin
        rd_en = 1'b1;
        if (ONE_PORT) begin
          ra1    = half ? f_rm : f_rn;
          rd_tag = {1'b0, half};
        end else begin
          ra1 = f_rn;
          ra2 = f_rm;
        end
      end
      S_RD1: begin
        // MLA reads Ra on both slots; long accumulate reads RdLo then RdHi
        rd_en = 1'b1;
        if (ONE_PORT) begin
          ra1    = half ? (long_q ? f_rd : f_ra) : f_ra;
          rd_tag = {1'b1, half};
        end else begin
          ra1    = f_ra;
          ra2    = long_q ? f_rd : f_ra;
          rd_tag = 2'd2;
        end
      end
      S_WB0: begin
        we = 1'b1;
        wa = long_q ? f_ra : f_rd;
      end
      S_WB1: begin
        we   = 1'b1;
        wa   = f_rd;
        wsel = 1'b1;
      end
      default: ;
    endcase
  end

  assign long_mul   = long_q;
  assign signed_mul = signed_q;
  assign accumulate = acc_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mul_field_sequencer.sv
// tb/tb_mul_field_sequencer.sv - directed self-checking bench for mul_field_sequencer
module tb_mul_field_sequencer;

`ifdef LONG_MUL_EN
  localparam logic LM = 1'b1;
`else
  localparam logic LM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        op_mul = 1'b0;
  logic        in_valid2 = 1'b0, in_valid1 = 1'b0;
  logic        exec_done2 = 1'b0, exec_done1 = 1'b0;

  logic       in_ready2, rd_en2, we2, wsel2, long2, signed2, acc2, illegal2;
  logic [3:0] ra1_2, ra2_2, wa2;
  logic [1:0] tag2;
  logic       in_ready1, rd_en1, we1, wsel1, long1, signed1, acc1, illegal1;
  logic [3:0] ra1_1, ra2_1, wa1;
  logic [1:0] tag1;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mul_field_sequencer #(.REG_AW(4), .RD_PORTS(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .instr(instr), .op_mul(op_mul), .rd_en(rd_en2), .ra1(ra1_2), .ra2(ra2_2),
    .rd_tag(tag2), .exec_done(exec_done2), .we(we2), .wa(wa2), .wsel(wsel2),
    .long_mul(long2), .signed_mul(signed2), .accumulate(acc2), .illegal(illegal2)
  );

  mul_field_sequencer #(.REG_AW(4), .RD_PORTS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .instr(instr), .op_mul(op_mul), .rd_en(rd_en1), .ra1(ra1_1), .ra2(ra2_1),
    .rd_tag(tag1), .exec_done(exec_done1), .we(we1), .wa(wa1), .wsel(wsel1),
    .long_mul(long1), .signed_mul(signed1), .accumulate(acc1), .illegal(illegal1)
  );

  // {in_ready, rd_en, ra1, ra2, rd_tag, we, wa, wsel, long, signed, acc, illegal}
  logic [21:0] s2, s1;
  assign s2 = {in_ready2, rd_en2, ra1_2, ra2_2, tag2, we2, wa2, wsel2, long2, signed2, acc2, illegal2};
  assign s1 = {in_ready1, rd_en1, ra1_1, ra2_1, tag1, we1, wa1, wsel1, long1, signed1, acc1, illegal1};

  function automatic logic [21:0] mk(input logic ir, input logic re, input logic [3:0] a1,
                                     input logic [3:0] a2, input logic [1:0] tg, input logic w,
                                     input logic [3:0] a, input logic ws, input logic lg,
                                     input logic sg, input logic ac, input logic il);
    return {ir, re, a1, a2, tg, w, a, ws, lg, sg, ac, il};
  endfunction

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Offer one instruction to the selected instance; returns at the negedge of cycle N+1
  task automatic accept(input logic one, input logic [31:0] ins, input logic om);
    @(negedge clk);
    instr  = ins;
    op_mul = om;
    if (one) in_valid1 = 1'b1; else in_valid2 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  localparam logic [21:0] IDLE_V = 22'h200000;
  localparam logic [21:0] ZERO_V = 22'h000000;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick;
    chk("reset_idle2", s2, IDLE_V);
    chk("reset_idle1", s1, IDLE_V);
    tick;
    reset = 1'b0;
    tick;

    // MUL, two ports; exec_done during RD0 must be ignored
    accept(1'b0, 32'hE0030291, 1'b1);
    chk("mul_rd0", s2, mk(0, 1, 4'd1, 4'd2, 2'd0, 0, 4'd0, 0, 0, 0, 0, 0));
    exec_done2 = 1'b1;
    tick; exec_done2 = 1'b0;
    chk("mul_wait_n2", s2, ZERO_V);
    tick;
    chk("mul_wait_n3", s2, ZERO_V);
    tick; exec_done2 = 1'b1;
    chk("mul_wait_n4", s2, ZERO_V);
    tick; exec_done2 = 1'b0;
    chk("mul_wb_n5", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, 4'd3, 0, 0, 0, 0, 0));
    tick;
    chk("mul_idle_n6", s2, IDLE_V);

    // MLA, two ports
    accept(1'b0, 32'hE0234291, 1'b1);
    chk("mla_rd0", s2, mk(0, 1, 4'd1, 4'd2, 2'd0, 0, 4'd0, 0, 0, 0, 1, 0));
    tick;
    chk("mla_rd1", s2, mk(0, 1, 4'd4, 4'd4, 2'd2, 0, 4'd0, 0, 0, 0, 1, 0));
    tick; exec_done2 = 1'b1;
    chk("mla_wait", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 0, 0, 0, 1, 0));
    tick; exec_done2 = 1'b0;
    chk("mla_wb", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, 4'd3, 0, 0, 0, 1, 0));
    tick;
    chk("mla_idle", s2, IDLE_V);

    // UMULL encoding: long sequence when enabled, MUL with illegal pulse otherwise
    accept(1'b0, 32'hE0854392, 1'b1);
    chk("umull_rd0", s2, mk(0, 1, 4'd2, 4'd3, 2'd0, 0, 4'd0, 0, LM, 0, 0, !LM));
    tick; exec_done2 = 1'b1;
    chk("umull_wait", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 0, LM, 0, 0, 0));
    tick; exec_done2 = 1'b0;
    chk("umull_wb0", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, LM ? 4'd4 : 4'd5, 0, LM, 0, 0, 0));
    tick;
    if (LM) begin
      chk("umull_wb1", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, 4'd5, 1, 1, 0, 0, 0));
      tick;
    end
    chk("umull_idle", s2, IDLE_V);

    // Data-processing; bit 23 set but op_mul=0 must not flag anything
    accept(1'b0, 32'hE0812003, 1'b0);
    chk("dp_rd0", s2, mk(0, 1, 4'd1, 4'd3, 2'd0, 0, 4'd0, 0, 0, 0, 0, 0));
    tick; exec_done2 = 1'b1;
    chk("dp_wait", s2, ZERO_V);
    tick; exec_done2 = 1'b0;
    chk("dp_wb", s2, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, 4'd2, 0, 0, 0, 0, 0));
    tick;
    chk("dp_idle", s2, IDLE_V);

    // SMLAL, one read port: four operand cycles
    accept(1'b1, 32'hE0E54392, 1'b1);
    chk("smlal_rd_c0", s1, mk(0, 1, 4'd2, 4'd0, 2'd0, 0, 4'd0, 0, LM, LM, 1, !LM));
    tick;
    chk("smlal_rd_c1", s1, mk(0, 1, 4'd3, 4'd0, 2'd1, 0, 4'd0, 0, LM, LM, 1, 0));
    tick;
    chk("smlal_rd_c2", s1, mk(0, 1, 4'd4, 4'd0, 2'd2, 0, 4'd0, 0, LM, LM, 1, 0));
    tick;
    chk("smlal_rd_c3", s1, mk(0, 1, LM ? 4'd5 : 4'd4, 4'd0, 2'd3, 0, 4'd0, 0, LM, LM, 1, 0));
    tick; exec_done1 = 1'b1;
    chk("smlal_wait", s1, mk(0, 0, 4'd0, 4'd0, 2'd0, 0, 4'd0, 0, LM, LM, 1, 0));
    tick; exec_done1 = 1'b0;
    chk("smlal_wb0", s1, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, LM ? 4'd4 : 4'd5, 0, LM, LM, 1, 0));
    tick;
    if (LM) begin
      chk("smlal_wb1", s1, mk(0, 0, 4'd0, 4'd0, 2'd0, 1, 4'd5, 1, 1, 1, 1, 0));
      tick;
    end
    chk("smlal_idle", s1, IDLE_V);

    // Reset while waiting for execute: abort at once, no writeback afterwards
    accept(1'b0, 32'hE0030291, 1'b1);
    tick;
    chk("rst_pre_wait", s2, ZERO_V);
    exec_done2 = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_abort", s2, IDLE_V);
    tick;
    chk("rst_held", s2, IDLE_V);
    reset = 1'b0;
    exec_done2 = 1'b0;
    tick;
    chk("rst_after", s2, IDLE_V);
    tick;
    chk("rst_no_we", s2, IDLE_V);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
